// File: rtl/fft_pkg.sv
// Shared FFT output-path constants and the output FIFO state encoding.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package fft_pkg;

    localparam int SAMPLE_W    = 64;                    // real[63:32], imag[31:0]
    localparam int BLOCK_W     = 512;                   // MC transfer width
    localparam int NUM_SAMPLES = 1024;                  // samples per FFT frame
    localparam int SPB         = BLOCK_W / SAMPLE_W;    // samples per block
    localparam int NUM_BLOCKS  = NUM_SAMPLES / SPB;     // blocks per frame
    localparam int SLOT_W      = $clog2(SPB);
    localparam int BLK_IDX_W   = $clog2(NUM_BLOCKS);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FILL  = 2'd1,
        READY = 2'd2
    } outfifo_state_t;

endpackage

// File: rtl/fft_out_packer.sv
// Packs SPB consecutive samples into one BLOCK_W block, slot k at bits [64k+63:64k].
// Latency: block emitted combinationally in the cycle its last sample is written.
// Backpressure: none; every wr_i is consumed, gaps simply hold the slot counter.
//
// Ports: clk/rst (sync, active-high); wr_i + sample_i write one sample;
//        blk_vld_o pulses with the completed block on blk_dat_o (includes sample_i).
module fft_out_packer
    import fft_pkg::*;
(
    input  logic                clk,
    input  logic                rst,
    input  logic                wr_i,
    input  logic [SAMPLE_W-1:0] sample_i,
    output logic                blk_vld_o,
    output logic [BLOCK_W-1:0]  blk_dat_o
);

    logic [BLOCK_W-1:0] pack_q, pack_d;
    logic [SLOT_W-1:0]  slot_q, slot_d;

    always_comb begin
        pack_d = pack_q;
        slot_d = slot_q;
        if (wr_i) begin
            pack_d[int'(slot_q) * SAMPLE_W +: SAMPLE_W] = sample_i;
            slot_d = slot_q + SLOT_W'(1);
        end
    end

    // The finished block is the merged next-state, so the arriving last
    // sample lands in storage on the same edge it is captured.
    assign blk_vld_o = wr_i && (slot_q == SLOT_W'(SPB - 1));
    assign blk_dat_o = pack_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            pack_q <= '0;
            slot_q <= '0;
        end else begin
            pack_q <= pack_d;
            slot_q <= slot_d;
        end
    end

endmodule

// File: rtl/fft_out_fifo.sv
// FFT result buffer: collects one frame of samples as blocks, then hands them to the MC.
// Latency: outFifoReady one cycle after the last sample edge; next block one cycle after accelWrBlkDone.
// Backpressure: none upstream; writes while READY are dropped and flagged in overflowErr.
//
// Ports: clk/rst (sync, active-high); loadOutBuffer/sampleIn sample write;
//        accelWrBlkDone retires the current block; mcDataOut/mcDataOutValid current block;
//        outFifoReady/outFifoEmpty frame status; overflowErr sticky drop flag.
module fft_out_fifo
    import fft_pkg::*;
(
    input  logic                clk,
    input  logic                rst,
    input  logic                loadOutBuffer,
    input  logic [SAMPLE_W-1:0] sampleIn,
    input  logic                accelWrBlkDone,
    output logic [BLOCK_W-1:0]  mcDataOut,
    output logic                mcDataOutValid,
    output logic                outFifoReady,
    output logic                outFifoEmpty,
    output logic                overflowErr
);

    localparam logic [BLK_IDX_W-1:0] LAST_BLK = BLK_IDX_W'(NUM_BLOCKS - 1);

    outfifo_state_t         state_q, state_d;
    logic [BLK_IDX_W-1:0]   wr_blk_q, wr_blk_d;
    logic [BLK_IDX_W-1:0]   rd_ptr_q, rd_ptr_d;
    logic                   ovf_q, ovf_d;

    logic                   pk_wr;
    logic                   blk_vld;
    logic [BLOCK_W-1:0]     blk_dat;

    logic [BLOCK_W-1:0]     mem [NUM_BLOCKS];

    // Samples are only accepted while no frame is waiting to drain.
    assign pk_wr = loadOutBuffer && (state_q != READY);

    fft_out_packer u_packer (
        .clk       (clk),
        .rst       (rst),
        .wr_i      (pk_wr),
        .sample_i  (sampleIn),
        .blk_vld_o (blk_vld),
        .blk_dat_o (blk_dat)
    );

    // Storage is deliberately not reset so it can map onto RAM.
    always_ff @(posedge clk) begin
        if (blk_vld) begin
            mem[wr_blk_q] <= blk_dat;
        end
    end

    always_comb begin
        state_d  = state_q;
        wr_blk_d = wr_blk_q;
        rd_ptr_d = rd_ptr_q;
        ovf_d    = ovf_q;

        // Block index wraps to 0 naturally after the last block of a frame.
        if (blk_vld) begin
            wr_blk_d = wr_blk_q + BLK_IDX_W'(1);
        end

        case (state_q)
            IDLE: begin
                if (loadOutBuffer) begin
                    state_d = FILL;
                end
            end
            FILL: begin
                if (blk_vld && (wr_blk_q == LAST_BLK)) begin
                    state_d = READY;
                end
            end
            READY: begin
                if (loadOutBuffer) begin
                    ovf_d = 1'b1;
                end
                if (accelWrBlkDone) begin
                    rd_ptr_d = rd_ptr_q + BLK_IDX_W'(1);
                    if (rd_ptr_q == LAST_BLK) begin
                        state_d = IDLE;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            wr_blk_q <= '0;
            rd_ptr_q <= '0;
            ovf_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            wr_blk_q <= wr_blk_d;
            rd_ptr_q <= rd_ptr_d;
            ovf_q    <= ovf_d;
        end
    end

    assign outFifoReady   = (state_q == READY);
    assign mcDataOutValid = (state_q == READY);
    assign outFifoEmpty   = (state_q == IDLE);
    assign overflowErr    = ovf_q;
    assign mcDataOut      = (state_q == READY) ? mem[rd_ptr_q] : '0;

endmodule
